// File: rtl/cpu_types.sv
// Shared CPU pipeline types used by the memory-access stage and its neighbours.
package cpu_types;

    // Access width of a load or store.
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    // Memory-access FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Decoded instruction fields the memory stage cares about.
    typedef struct packed {
        logic      mem_read;
        logic      mem_write;
        mem_size_t mem_size;
        logic      mem_unsigned;
    } instruction_t;

    // Result carried toward writeback; value doubles as the effective address on input.
    typedef struct packed {
        logic        valid;
        logic [4:0]  target;
        logic [31:0] value;
    } result_t;

    // Stage-to-stage status word.
    typedef struct packed {
        logic         valid;
        logic         ready;
        instruction_t instruction;
        result_t      data;
        logic [31:0]  reg_rs2;
    } stage_status_t;

endpackage

// File: rtl/memory_access_pkg.sv
// Helpers for the memory-access stage: alignment rule and store lane formatting.
package memory_access_pkg;
    import cpu_types::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic is_aligned(mem_size_t size, logic [1:0] offset);
        case (size)
            MEM_BYTE: return 1'b1;
            MEM_HALF: return ~offset[0];
            default:  return (offset == 2'b00);
        endcase
    endfunction

    // Byte-enable mask for a store at the given lane offset.
    function automatic logic [MASK_W-1:0] store_mask(mem_size_t size, logic [1:0] offset);
        case (size)
            MEM_BYTE: return 4'b0001 << offset;
            MEM_HALF: return 4'b0011 << offset;
            default:  return 4'b1111;
        endcase
    endfunction

    // Store data replicated across lanes so the mask alone selects the bytes.
    function automatic logic [DATA_W-1:0] store_data(mem_size_t size, logic [DATA_W-1:0] rs2);
        case (size)
            MEM_BYTE: return {4{rs2[7:0]}};
            MEM_HALF: return {2{rs2[15:0]}};
            default:  return rs2;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/response bundle.
//
// Handshake: mem_req is held high from the issue cycle until the cycle in
// which mem_ack is seen; addr/we/wdata/wmask are stable for that whole window.
// mem_ack is a single-cycle response; rdata is valid in the ack cycle only.
interface memory_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_extend.sv
// Lane shift and sign/zero extension of a captured load word.
module load_extend
    import cpu_types::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Move the addressed byte lane down to bit 0, then extend to 32 bits.
    always_comb begin
        shifted = data >> {offset, 3'b000};
        case (size)
            MEM_BYTE: result = is_unsigned ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            MEM_HALF: result = is_unsigned ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default:  result = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues loads/stores to data memory, waits for
// the ack with a watchdog, and formats load data for writeback.
//
// Upstream handshake: stage_out.ready=0 means the stage is busy and stage_in
// must be held stable; stage_out.valid is 0 whenever ready is 0.
// MAX_WAIT must be at least 1.
module memory_access
    import cpu_types::*;
    import memory_access_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  stage_status_t   stage_in,
    output stage_status_t   stage_out,
    memory_access_if.master mem,
    output logic            mem_fault,
    output mem_state_t      state_dbg
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    mem_state_t        state;
    mem_state_t        state_next;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timed_out;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] load_value;

    logic [ADDR_W-1:0] addr;
    logic [1:0]        offset;
    logic              is_mem_op;
    logic              is_store;
    logic              is_load;
    logic              aligned;
    logic              cnt_hit;
    logic [MASK_W-1:0] req_wmask;

    logic              req_c;
    logic              we_c;
    logic [MASK_W-1:0] wmask_c;

    assign addr      = stage_in.data.value;
    assign offset    = addr[1:0];
    assign is_store  = stage_in.instruction.mem_write;
    assign is_load   = stage_in.instruction.mem_read & ~stage_in.instruction.mem_write;
    assign is_mem_op = stage_in.valid
                     & (stage_in.instruction.mem_read | stage_in.instruction.mem_write);
    assign aligned   = is_aligned(stage_in.instruction.mem_size, offset);
    assign req_wmask = is_store ? store_mask(stage_in.instruction.mem_size, offset) : '0;
    // Reaching MAX_WAIT happens at the end of the cycle where the count is MAX_WAIT-1.
    assign cnt_hit   = (wait_cnt == CNT_W'(MAX_WAIT - 1));

    load_extend u_load_extend (
        .data        (rdata_q),
        .offset      (offset),
        .size        (stage_in.instruction.mem_size),
        .is_unsigned (stage_in.instruction.mem_unsigned),
        .result      (load_value)
    );

    assign mem.mem_req   = req_c;
    assign mem.mem_we    = we_c;
    assign mem.mem_wmask = wmask_c;
    assign mem.mem_addr  = {addr[31:2], 2'b00};
    assign mem.mem_wdata = store_data(stage_in.instruction.mem_size, stage_in.reg_rs2);
    assign state_dbg     = state;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Watchdog counter, timeout flag and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (state == IDLE) begin
                wait_cnt  <= '0;
                timed_out <= 1'b0;
            end else if (state == WAIT) begin
                if (mem.mem_ack) begin
                    rdata_q <= mem.mem_rdata;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (cnt_hit) begin
                        timed_out <= 1'b1;
                    end
                end
            end
        end
    end

    // Next-state logic, memory request and stage outputs.
    always_comb begin
        state_next      = state;
        stage_out       = stage_in;
        stage_out.ready = 1'b1;
        req_c           = 1'b0;
        we_c            = 1'b0;
        wmask_c         = '0;
        mem_fault       = 1'b0;

        case (state)
            IDLE: begin
                if (is_mem_op) begin
                    if (aligned) begin
                        req_c           = 1'b1;
                        we_c            = is_store;
                        wmask_c         = req_wmask;
                        stage_out.ready = 1'b0;
                        stage_out.valid = 1'b0;
                        state_next      = WAIT;
                    end else begin
                        // Misaligned: no bus access, completes now with no result.
                        mem_fault            = 1'b1;
                        stage_out.data.valid = 1'b0;
                    end
                end
            end
            WAIT: begin
                req_c           = 1'b1;
                we_c            = is_store;
                wmask_c         = req_wmask;
                stage_out.ready = 1'b0;
                stage_out.valid = 1'b0;
                if (mem.mem_ack || cnt_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next           = IDLE;
                mem_fault            = timed_out;
                stage_out.data.valid = is_load & ~timed_out;
                if (is_load && !timed_out) begin
                    stage_out.data.value = load_value;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Reset quiets the bus immediately, abandoning any access in flight.
        if (rst) begin
            req_c           = 1'b0;
            we_c            = 1'b0;
            wmask_c         = '0;
            mem_fault       = 1'b0;
            stage_out.ready = 1'b1;
            stage_out.valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed testbench for memory_access (MAX_WAIT=4).
module tb_memory_access;
    import cpu_types::*;

    logic          clk = 1'b0;
    logic          rst;
    stage_status_t stage_in;
    stage_status_t stage_out;
    logic          mem_fault;
    mem_state_t    state_dbg;

    memory_access_if mem_bus ();

    memory_access #(.MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .stage_in  (stage_in),
        .stage_out (stage_out),
        .mem       (mem_bus),
        .mem_fault (mem_fault),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got running, expected finished)");
        $fatal(1);
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        stage_in = '0;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input mem_size_t sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] tgt);
        stage_in                          = '0;
        stage_in.valid                    = 1'b1;
        stage_in.instruction.mem_read     = rd;
        stage_in.instruction.mem_write    = wr;
        stage_in.instruction.mem_size     = sz;
        stage_in.instruction.mem_unsigned = uns;
        stage_in.data.value               = addr;
        stage_in.data.target              = tgt;
        stage_in.data.valid               = 1'b1;
        stage_in.reg_rs2                  = rs2;
    endtask

    // Runs one op (already driven) until stage_out.ready=1; acks on WAIT cycle ack_at (0 = never).
    task automatic run_op(input int ack_at, input logic [31:0] rdata,
                          output int low, output stage_status_t done, output logic fault_done,
                          output int req_cycles, output logic [31:0] addr0, output logic [3:0] mask0,
                          output logic [31:0] wdata0, output logic we0, output logic hold_ok);
        bit finished;
        int guard;
        low = 0; req_cycles = 0; hold_ok = 1'b1; finished = 0; guard = 0;
        done = '0; fault_done = 1'b0; addr0 = '0; mask0 = '0; wdata0 = '0; we0 = 1'b0;
        while (!finished && guard < 40) begin
            guard++;
            @(negedge clk);
            if (stage_out.ready) begin
                done       = stage_out;
                fault_done = mem_fault;
                finished   = 1;
            end else begin
                if (mem_bus.mem_req) begin
                    if (req_cycles == 0) begin
                        addr0 = mem_bus.mem_addr; mask0 = mem_bus.mem_wmask;
                        wdata0 = mem_bus.mem_wdata; we0 = mem_bus.mem_we;
                    end else if (mem_bus.mem_addr !== addr0 || mem_bus.mem_wmask !== mask0 ||
                                 mem_bus.mem_wdata !== wdata0 || mem_bus.mem_we !== we0) begin
                        hold_ok = 1'b0;
                    end
                    req_cycles++;
                end else begin
                    hold_ok = 1'b0;
                end
                if (stage_out.valid || mem_fault) hold_ok = 1'b0;
                low++;
                if (ack_at > 0 && low == ack_at + 1) begin
                    mem_bus.mem_ack   = 1'b1;
                    mem_bus.mem_rdata = rdata;
                end
                @(posedge clk);
                #1;
                mem_bus.mem_ack = 1'b0;
            end
        end
        if (!finished) check("op_bound", 32'd0, 32'd1);
    endtask

    int            low;
    int            reqs;
    stage_status_t done;
    logic          fdone;
    logic [31:0]   a0;
    logic [3:0]    m0;
    logic [31:0]   w0;
    logic          we0;
    logic          hold;

    // Load with expected value taken from the scoreboard queue.
    task automatic check_load(input string tag, input int exp_low, input logic [4:0] tgt);
        check({tag, "_latency"}, 32'(low), 32'(exp_low));
        check({tag, "_hold"}, 32'(hold), 32'd1);
        check({tag, "_we"}, 32'(we0), 32'd0);
        check({tag, "_fault"}, 32'(fdone), 32'd0);
        check({tag, "_dvalid"}, 32'(done.data.valid), 32'd1);
        check({tag, "_valid"}, 32'(done.valid), 32'd1);
        check({tag, "_target"}, 32'(done.data.target), 32'(tgt));
        if (exp_q.size() > 0) check({tag, "_value"}, done.data.value, exp_q.pop_front());
        else check({tag, "_queue"}, 32'd0, 32'd1);
    endtask

    task automatic check_store(input string tag, input logic [31:0] e_addr, input logic [3:0] e_mask,
                               input logic [31:0] e_wdata);
        check({tag, "_latency"}, 32'(low), 32'd2);
        check({tag, "_addr"}, a0, e_addr);
        check({tag, "_wmask"}, 32'(m0), 32'(e_mask));
        check({tag, "_wdata"}, w0, e_wdata);
        check({tag, "_we"}, 32'(we0), 32'd1);
        check({tag, "_hold"}, 32'(hold), 32'd1);
        check({tag, "_dvalid"}, 32'(done.data.valid), 32'd0);
        check({tag, "_fault"}, 32'(fdone), 32'd0);
    endtask

    initial begin
        // Reset with a load presented: nothing may reach the bus.
        rst = 1'b1;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = '0;
        drive_op(1, 0, MEM_WORD, 0, 32'h100, 32'h0, 5'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(mem_bus.mem_req), 32'd0);
        check("rst_we", 32'(mem_bus.mem_we), 32'd0);
        check("rst_wmask", 32'(mem_bus.mem_wmask), 32'd0);
        check("rst_fault", 32'(mem_fault), 32'd0);
        check("rst_ready", 32'(stage_out.ready), 32'd1);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        // Stray ack in IDLE is ignored.
        @(posedge clk); #1;
        rst = 1'b0;
        idle_in();
        mem_bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_state", 32'(state_dbg), 32'(IDLE));
        check("stray_ack_fault", 32'(mem_fault), 32'd0);

        // Non-memory op passes through.
        @(posedge clk); #1;
        stage_in = '0;
        stage_in.valid = 1'b1;
        stage_in.data.value = 32'h1234_5678;
        stage_in.data.valid = 1'b1;
        @(negedge clk);
        check("pass_ready", 32'(stage_out.ready), 32'd1);
        check("pass_valid", 32'(stage_out.valid), 32'd1);
        check("pass_value", stage_out.data.value, 32'h1234_5678);
        check("pass_req", 32'(mem_bus.mem_req), 32'd0);

        // Load bits set but not valid: still passthrough.
        @(posedge clk); #1;
        drive_op(1, 0, MEM_WORD, 0, 32'h100, 32'h0, 5'd2);
        stage_in.valid = 1'b0;
        @(negedge clk);
        check("inval_req", 32'(mem_bus.mem_req), 32'd0);
        check("inval_ready", 32'(stage_out.ready), 32'd1);

        // Word load at 0x100, ack on second WAIT cycle.
        @(posedge clk); #1;
        drive_op(1, 0, MEM_WORD, 0, 32'h100, 32'h0, 5'd5);
        exp_q.push_back(32'hDEAD_BEEF);
        run_op(2, 32'hDEAD_BEEF, low, done, fdone, reqs, a0, m0, w0, we0, hold);
        check("lw_addr", a0, 32'h100);
        check_load("lw", 3, 5'd5);

        // Back-to-back signed then unsigned byte loads at 0x103.
        @(posedge clk); #1;
        drive_op(1, 0, MEM_BYTE, 0, 32'h103, 32'h0, 5'd6);
        exp_q.push_back(32'hFFFF_FF80);
        run_op(1, 32'h8011_2233, low, done, fdone, reqs, a0, m0, w0, we0, hold);
        check("lb_addr", a0, 32'h100);
        check_load("lb", 2, 5'd6);

        @(posedge clk); #1;
        drive_op(1, 0, MEM_BYTE, 1, 32'h103, 32'h0, 5'd7);
        exp_q.push_back(32'h0000_0080);
        run_op(1, 32'h8011_2233, low, done, fdone, reqs, a0, m0, w0, we0, hold);
        check_load("lbu", 2, 5'd7);

        // Half loads.
        @(posedge clk); #1;
        drive_op(1, 0, MEM_HALF, 0, 32'h102, 32'h0, 5'd8);
        exp_q.push_back(32'hFFFF_8001);
        run_op(1, 32'h8001_1234, low, done, fdone, reqs, a0, m0, w0, we0, hold);
        check_load("lh", 2, 5'd8);

        @(posedge clk); #1;
        drive_op(1, 0, MEM_HALF, 1, 32'h100, 32'h0, 5'd9);
        exp_q.push_back(32'h0000_F0F0);
        run_op(1, 32'h1234_F0F0, low, done, fdone, reqs, a0, m0, w0, we0, hold);
        check_load("lhu", 2, 5'd9);

        // Stores.
        @(posedge clk); #1;
        drive_op(0, 1, MEM_HALF, 0, 32'h102, 32'h0000_ABCD, 5'd0);
        run_op(1, 32'h0, low, done, fdone, reqs, a0, m0, w0, we0, hold);
        check_store("sh", 32'h100, 4'b1100, 32'hABCD_ABCD);

        @(posedge clk); #1;
        drive_op(0, 1, MEM_BYTE, 0, 32'h101, 32'h1234_5678, 5'd0);
        run_op(1, 32'h0, low, done, fdone, reqs, a0, m0, w0, we0, hold);
        check_store("sb", 32'h100, 4'b0010, 32'h7878_7878);

        @(posedge clk); #1;
        drive_op(0, 1, MEM_WORD, 0, 32'h204, 32'hCAFE_F00D, 5'd0);
        run_op(1, 32'h0, low, done, fdone, reqs, a0, m0, w0, we0, hold);
        check_store("sw", 32'h204, 4'b1111, 32'hCAFE_F00D);

        // Misaligned word load at 0x101.
        @(posedge clk); #1;
        drive_op(1, 0, MEM_WORD, 0, 32'h101, 32'h0, 5'd3);
        run_op(1, 32'h0, low, done, fdone, reqs, a0, m0, w0, we0, hold);
        check("mis_lw_low", 32'(low), 32'd0);
        check("mis_lw_fault", 32'(fdone), 32'd1);
        check("mis_lw_req", 32'(mem_bus.mem_req), 32'd0);
        check("mis_lw_dvalid", 32'(done.data.valid), 32'd0);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        check("mis_lw_pulse", 32'(mem_fault), 32'd0);

        // Misaligned half store at 0x103.
        @(posedge clk); #1;
        drive_op(0, 1, MEM_HALF, 0, 32'h103, 32'h5555_5555, 5'd0);
        @(negedge clk);
        check("mis_sh_fault", 32'(mem_fault), 32'd1);
        check("mis_sh_req", 32'(mem_bus.mem_req), 32'd0);
        check("mis_sh_ready", 32'(stage_out.ready), 32'd1);
        @(posedge clk); #1;
        idle_in();

        // Timeout: no ack for MAX_WAIT WAIT cycles.
        @(posedge clk); #1;
        drive_op(1, 0, MEM_WORD, 0, 32'h300, 32'h0, 5'd10);
        run_op(0, 32'h0, low, done, fdone, reqs, a0, m0, w0, we0, hold);
        check("to_latency", 32'(low), 32'd5);
        check("to_fault", 32'(fdone), 32'd1);
        check("to_req_drop", 32'(mem_bus.mem_req), 32'd0);
        check("to_dvalid", 32'(done.data.valid), 32'd0);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        check("to_pulse", 32'(mem_fault), 32'd0);

        // Ack on the fourth WAIT cycle beats the timeout.
        @(posedge clk); #1;
        drive_op(1, 0, MEM_WORD, 0, 32'h300, 32'h0, 5'd11);
        exp_q.push_back(32'h5A5A_5A5A);
        run_op(4, 32'h5A5A_5A5A, low, done, fdone, reqs, a0, m0, w0, we0, hold);
        check_load("ack4", 5, 5'd11);

        // Reset during the last WAIT cycle before a timeout.
        @(posedge clk); #1;
        drive_op(1, 0, MEM_WORD, 0, 32'h400, 32'h0, 5'd12);
        @(negedge clk);
        check("rstw_issue_req", 32'(mem_bus.mem_req), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("rstw_in_wait", 32'(state_dbg), 32'(WAIT));
        rst = 1'b1;
        @(negedge clk);
        check("rstw_req_during", 32'(mem_bus.mem_req), 32'd0);
        check("rstw_fault_during", 32'(mem_fault), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_in();
        @(negedge clk);
        check("rstw_state", 32'(state_dbg), 32'(IDLE));
        check("rstw_req", 32'(mem_bus.mem_req), 32'd0);
        check("rstw_ready", 32'(stage_out.ready), 32'd1);
        check("rstw_fault", 32'(mem_fault), 32'd0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The module SHALL have one parameter: MAX_WAIT, default 255, the number of cycles waited for mem_ack before the access is aborted.
REQ-002 The module SHALL have port clk, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port stage_in, input, stage_status_t: the execute-stage result; stage_in.data.value carries the effective address.
REQ-005 The module SHALL have port stage_out, output, stage_status_t: the result toward writeback.
REQ-006 The module SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32), mem_wmask (output, 4): the data-memory request.
REQ-007 The module SHALL have ports mem_rdata (input, 32) and mem_ack (input, 1): the data-memory response.
REQ-008 The module SHALL have port mem_fault, output, 1 bit: a one-cycle pulse on misalignment or watchdog timeout.

Function
REQ-009 A memory op is stage_in.valid with instruction.mem_read or instruction.mem_write set; every other input SHALL pass through combinationally with stage_out.ready=1.
REQ-010 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-011 IDLE to WAIT: on an aligned memory op, asserting mem_req in the same cycle.
REQ-012 WAIT to DONE: on mem_ack.
REQ-013 DONE to IDLE: unconditionally after one cycle.
REQ-014 mem_req SHALL stay high from the issue cycle through the ack cycle; mem_addr, mem_we, mem_wdata and mem_wmask SHALL stay stable while mem_req is high.
REQ-015 mem_addr SHALL equal the address with bits [1:0] cleared.
REQ-016 For stores, mem_wmask SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-017 For stores, mem_wdata SHALL be reg_rs2 replicated across lanes.
REQ-018 Alignment rule: a half access SHALL have addr[0]=0 and a word access SHALL have addr[1:0]=0; otherwise the op is misaligned.
REQ-019 A misaligned op SHALL NOT issue mem_req; it SHALL pulse mem_fault and complete in one cycle with stage_out.data.valid=0.
REQ-020 stage_out.ready SHALL be 0 in the issue cycle and in WAIT, and 1 in DONE; the upstream holds stage_in stable while ready is 0.
REQ-021 stage_out.valid SHALL be 0 while ready is 0.
REQ-022 The mem_rdata lane SHALL be captured on the ack cycle into a 32-bit register.
REQ-023 Loads SHALL shift the captured data right by 8*addr[1:0], then zero-extend or sign-extend per instruction.mem_size and mem_unsigned.
REQ-024 In DONE, a load SHALL drive stage_out.data.value = the extended load data and stage_out.data.valid=1, using stage_in.data.target.
REQ-025 In DONE, a store SHALL drive stage_out.data.valid=0.
REQ-026 A wait counter SHALL start at 0 on entry to WAIT and increment each WAIT cycle without ack.
REQ-027 When the counter reaches MAX_WAIT with no ack, the module SHALL drop mem_req, pulse mem_fault and go to DONE with data.valid=0.
REQ-028 An ack on the same cycle the counter reaches MAX_WAIT SHALL take precedence over the timeout.
REQ-029 mem_ack received in IDLE or DONE SHALL be ignored.
REQ-030 Back-to-back memory ops: a new op SHALL be accepted in the cycle after DONE, giving a minimum memory-op latency of 3 cycles with a 1-cycle ack.

Reset
REQ-031 On rst the FSM SHALL go to IDLE, the counter to 0 and the capture register to 0.
REQ-032 During and after rst, mem_req, mem_we and mem_fault SHALL be 0, mem_wmask 0, and stage_out.ready 1.
REQ-033 rst asserted during WAIT SHALL abandon the access with no fault pulse; the memory side is reset by the same rst.

Structure
REQ-034 cpu_types SHALL hold the mem_size_t enum (MEM_BYTE, MEM_HALF, MEM_WORD), the instruction fields mem_read, mem_write, mem_size and mem_unsigned, and the mem_state_t FSM enum.
REQ-035 One combinational sub-module, load_extend, SHALL perform the lane shift and sign/zero extension (inputs: data, offset, size, unsigned).

Verification
REQ-036 Word load at 0x100, mem_rdata=0xDEADBEEF, ack after 2 WAIT cycles -> ready=0 for 3 cycles, then data.value=0xDEADBEEF, data.valid=1.
REQ-037 Byte load signed at 0x103, rdata=0x80112233 -> data.value=0xFFFFFF80; the same load unsigned -> 0x00000080.
REQ-038 Half store at 0x102, rs2=0x0000ABCD -> mem_addr=0x100, mem_wmask=4'b1100, mem_wdata=0xABCDABCD, mem_we=1, data.valid=0.
REQ-039 Word load at 0x101 -> no mem_req, mem_fault pulses for 1 cycle, ready stays 1.
REQ-040 MAX_WAIT=4, no ack -> mem_fault pulses after 4 WAIT cycles and mem_req drops; a separate case with ack on cycle 4 -> no fault and data is returned.
REQ-041 rst during WAIT -> next cycle IDLE, mem_req=0, ready=1, no fault pulse.
